// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM encoding, reset PC and
// the canonical nop word.
package mips_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // 32-bit modulo increment; 32'hFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry parking register for a fetched word that could not enter IF/ID
// because decode was stalled. Clear wins over load, load wins over drain.
module fetch_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d   = instr_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, variable-latency imem handshake,
// one-entry fetch buffer and the IF/ID pipeline register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  input  logic        jumpD,
  input  logic [31:0] pcjumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic        fetchbusyF,
  output logic [1:0]  dbg_state
);

  // imem handshake: imem_req and imem_addr come straight from flops and stay
  // unchanged until an edge with imem_req & imem_ack, where imem_rdata is
  // taken. A request is never withdrawn before its ack, except by reset.

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q;
  logic         kill_q, kill_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         valid_q, valid_d;

  logic         redirect;
  logic [31:0]  target;
  logic         ack;
  logic         ack_ok;
  logic [31:0]  ack_pcp4;
  logic [31:0]  resume;
  logic         buf_load, buf_drain, buf_clear, buf_valid;
  logic [31:0]  buf_instr, buf_pcp4;

  assign redirect = (jumpD | pcsrcD) & ~stallD;
  assign target   = jumpD ? pcjumpD : pcbranchD;
  assign ack      = (state_q == FS_REQ) & imem_ack;
  // Ack data is usable only if not from a killed request and not overtaken
  // by a redirect in the same cycle.
  assign ack_ok   = ack & ~kill_q & ~redirect;
  assign ack_pcp4 = pc_plus4(addr_q);

  assign buf_load  = ack_ok & stallD;
  assign buf_drain = buf_valid & ~stallD;
  assign buf_clear = redirect;

  fetch_buffer u_fetch_buffer (
    .clk       (clk),
    .rst       (reset),
    .load_i    (buf_load),
    .drain_i   (buf_drain),
    .clear_i   (buf_clear),
    .instr_i   (imem_rdata),
    .pcplus4_i (ack_pcp4),
    .instr_o   (buf_instr),
    .pcplus4_o (buf_pcp4),
    .valid_o   (buf_valid)
  );

  // IF/ID: buffer first, then a same-cycle ack, otherwise a bubble.
  always_comb begin
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (!stallD) begin
      if (!redirect && buf_valid) begin
        instr_d = buf_instr;
        pcp4_d  = buf_pcp4;
        valid_d = 1'b1;
      end else if (ack_ok) begin
        instr_d = imem_rdata;
        pcp4_d  = ack_pcp4;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    resume  = pc_q;
    case (state_q)
      FS_IDLE: begin
        if (redirect) begin
          pc_d = target;
          if (!stallF) begin
            state_d = FS_REQ;
            addr_d  = target;
          end
        end else if (!stallF && !buf_valid) begin
          state_d = FS_REQ;
          addr_d  = pc_q;
        end
      end
      FS_REQ: begin
        if (imem_ack) begin
          if (kill_q) begin
            kill_d = 1'b0;
            resume = redirect ? target : pc_q;
          end else if (redirect) begin
            resume = target;
          end else begin
            resume = pc_plus4(pc_q);
          end
          pc_d = resume;
          if (buf_load) begin
            state_d = FS_HOLD;
          end else if (!stallF) begin
            state_d = FS_REQ;
            addr_d  = resume;
          end else begin
            state_d = FS_IDLE;
          end
        end else if (redirect) begin
          // The stale request must still complete; remember to drop its data.
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      FS_HOLD: begin
        if (redirect) begin
          pc_d = target;
          if (!stallF) begin
            state_d = FS_REQ;
            addr_d  = target;
          end else begin
            state_d = FS_IDLE;
          end
        end else if (!stallD) begin
          if (!stallF) begin
            state_d = FS_REQ;
            addr_d  = pc_q;
          end else begin
            state_d = FS_IDLE;
          end
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= 32'h0;
      req_q   <= 1'b0;
      kill_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= (state_d == FS_REQ);
      kill_q  <= kill_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign pcF        = pc_q;
  assign instrD     = instr_q;
  assign pcplus4D   = pcp4_q;
  assign validD     = valid_q;
  assign fetchbusyF = (state_q == FS_REQ) & ~imem_ack;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction
// memory whose word at address a is ~a.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        stallF, stallD, pcsrcD, jumpD;
  logic [31:0] pcbranchD, pcjumpD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] pcF, instrD, pcplus4D;
  logic        validD, fetchbusyF;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int ack_lat = 0;
  int wait_cnt = 0;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .stallF     (stallF),
    .stallD     (stallD),
    .pcsrcD     (pcsrcD),
    .pcbranchD  (pcbranchD),
    .jumpD      (jumpD),
    .pcjumpD    (pcjumpD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pcF        (pcF),
    .instrD     (instrD),
    .pcplus4D   (pcplus4D),
    .validD     (validD),
    .fetchbusyF (fetchbusyF),
    .dbg_state  (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: ack after ack_lat wait cycles of an outstanding request.
  assign imem_rdata = ~imem_addr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt = 0;
      imem_ack = 1'b0;
    end else begin
      if (imem_req && imem_ack) wait_cnt = 0;
      else if (imem_req) wait_cnt = wait_cnt + 1;
      #1;
      imem_ack = imem_req && (wait_cnt >= ack_lat);
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic reset_dut(input int lat);
    reset = 1'b1;
    stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
    pcbranchD = 32'h0; pcjumpD = 32'h0;
    ack_lat = lat;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
    pcbranchD = 32'h0; pcjumpD = 32'h0;
    repeat (2) @(posedge clk);
    #3;
    total++; if (pcF !== RST_PC) begin bad++; $display("FAIL reset_pcF got=%h exp=%h", pcF, RST_PC); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    total++; if (instrD !== 32'h0) begin bad++; $display("FAIL reset_instrD got=%h exp=0", instrD); end
    total++; if (pcplus4D !== 32'h0) begin bad++; $display("FAIL reset_pcplus4D got=%h exp=0", pcplus4D); end
    total++; if (validD !== 1'b0) begin bad++; $display("FAIL reset_validD got=%b exp=0", validD); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    reset_dut(0);
    for (int k = 0; k < 4; k++) begin
      step();
      a = RST_PC + 32'(4 * k);
      total++; if (imem_addr !== a) begin bad++; $display("FAIL zw_addr k=%0d got=%h exp=%h", k, imem_addr, a); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL zw_req k=%0d got=%b exp=1", k, imem_req); end
      total++; if (fetchbusyF !== 1'b0) begin bad++; $display("FAIL zw_busy k=%0d got=%b exp=0", k, fetchbusyF); end
      if (k == 0) begin
        total++; if (validD !== 1'b0) begin bad++; $display("FAIL zw_valid0 got=%b exp=0", validD); end
      end else begin
        total++; if (validD !== 1'b1) begin bad++; $display("FAIL zw_valid k=%0d got=%b exp=1", k, validD); end
        total++; if (pcplus4D !== a) begin bad++; $display("FAIL zw_pcplus4 k=%0d got=%h exp=%h", k, pcplus4D, a); end
        total++; if (instrD !== ~(a - 32'd4)) begin bad++; $display("FAIL zw_instr k=%0d got=%h exp=%h", k, instrD, ~(a - 32'd4)); end
      end
    end
  endtask

  task automatic test_wait3();
    logic [31:0] a;
    logic        exp_busy;
    reset_dut(3);
    for (int r = 0; r < 2; r++) begin
      a = RST_PC + 32'(4 * r);
      for (int c = 0; c < 4; c++) begin
        step();
        exp_busy = (c != 3);
        total++; if (imem_addr !== a) begin bad++; $display("FAIL w3_addr r=%0d c=%0d got=%h exp=%h", r, c, imem_addr, a); end
        total++; if (fetchbusyF !== exp_busy) begin bad++; $display("FAIL w3_busy r=%0d c=%0d got=%b exp=%b", r, c, fetchbusyF, exp_busy); end
        if (r == 1 && c == 0) begin
          total++; if (validD !== 1'b1) begin bad++; $display("FAIL w3_valid got=%b exp=1", validD); end
          total++; if (instrD !== ~RST_PC) begin bad++; $display("FAIL w3_instr got=%h exp=%h", instrD, ~RST_PC); end
        end else begin
          total++; if (validD !== 1'b0) begin bad++; $display("FAIL w3_bubble r=%0d c=%0d got=%b exp=0", r, c, validD); end
        end
        if (r == 1 && c == 1) begin
          total++; if (pcplus4D !== RST_PC + 32'd4) begin bad++; $display("FAIL w3_pcp4_hold got=%h exp=%h", pcplus4D, RST_PC + 32'd4); end
        end
      end
    end
    step();
    total++; if (instrD !== ~(RST_PC + 32'd4)) begin bad++; $display("FAIL w3_instr2 got=%h exp=%h", instrD, ~(RST_PC + 32'd4)); end
    total++; if (pcplus4D !== RST_PC + 32'd8) begin bad++; $display("FAIL w3_pcp4_2 got=%h exp=%h", pcplus4D, RST_PC + 32'd8); end
  endtask

  task automatic test_stall_hold();
    reset_dut(0);
    step();
    step();
    stallD = 1'b1; stallF = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL st_state i=%0d got=%0d exp=2", i, dbg_state); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL st_req i=%0d got=%b exp=0", i, imem_req); end
      total++; if (instrD !== ~RST_PC) begin bad++; $display("FAIL st_instr_held i=%0d got=%h exp=%h", i, instrD, ~RST_PC); end
      total++; if (pcF !== RST_PC + 32'd8) begin bad++; $display("FAIL st_pcF i=%0d got=%h exp=%h", i, pcF, RST_PC + 32'd8); end
    end
    stallD = 1'b0; stallF = 1'b0;
    step();
    total++; if (instrD !== ~(RST_PC + 32'd4)) begin bad++; $display("FAIL st_drain_instr got=%h exp=%h", instrD, ~(RST_PC + 32'd4)); end
    total++; if (pcplus4D !== RST_PC + 32'd8) begin bad++; $display("FAIL st_drain_pcp4 got=%h exp=%h", pcplus4D, RST_PC + 32'd8); end
    total++; if (imem_addr !== RST_PC + 32'd8) begin bad++; $display("FAIL st_next_addr got=%h exp=%h", imem_addr, RST_PC + 32'd8); end
    step();
    total++; if (instrD !== ~(RST_PC + 32'd8)) begin bad++; $display("FAIL st_after_instr got=%h exp=%h", instrD, ~(RST_PC + 32'd8)); end
    total++; if (pcplus4D !== RST_PC + 32'd12) begin bad++; $display("FAIL st_after_pcp4 got=%h exp=%h", pcplus4D, RST_PC + 32'd12); end
  endtask

  task automatic test_branch_kill();
    reset_dut(0);
    step();
    jumpD = 1'b1; pcjumpD = 32'h20; ack_lat = 2;
    step();
    jumpD = 1'b0;
    total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL bk_addr20 got=%h exp=00000020", imem_addr); end
    total++; if (validD !== 1'b0) begin bad++; $display("FAIL bk_flush got=%b exp=0", validD); end
    pcsrcD = 1'b1; pcbranchD = 32'h100;
    step();
    pcsrcD = 1'b0;
    total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL bk_stale_addr got=%h exp=00000020", imem_addr); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL bk_stale_req got=%b exp=1", imem_req); end
    total++; if (pcF !== 32'h100) begin bad++; $display("FAIL bk_pcF got=%h exp=00000100", pcF); end
    step();
    total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL bk_stale_addr2 got=%h exp=00000020", imem_addr); end
    step();
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL bk_target_addr got=%h exp=00000100", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      total++; if (validD !== 1'b0) begin bad++; $display("FAIL bk_discard i=%0d got=%b exp=0", i, validD); end
      step();
    end
    total++; if (validD !== 1'b1) begin bad++; $display("FAIL bk_valid got=%b exp=1", validD); end
    total++; if (instrD !== 32'hFFFF_FEFF) begin bad++; $display("FAIL bk_instr got=%h exp=fffffeff", instrD); end
    total++; if (pcplus4D !== 32'h104) begin bad++; $display("FAIL bk_pcp4 got=%h exp=00000104", pcplus4D); end
  endtask

  task automatic test_jump_priority();
    reset_dut(0);
    step();
    jumpD = 1'b1; pcjumpD = 32'h200; pcsrcD = 1'b1; pcbranchD = 32'h100; stallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (pcF !== RST_PC + 32'd4) begin bad++; $display("FAIL jp_ignored i=%0d got=%h exp=%h", i, pcF, RST_PC + 32'd4); end
      total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL jp_hold i=%0d got=%0d exp=2", i, dbg_state); end
    end
    stallD = 1'b0;
    step();
    jumpD = 1'b0; pcsrcD = 1'b0;
    total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL jp_addr got=%h exp=00000200", imem_addr); end
    total++; if (pcF !== 32'h200) begin bad++; $display("FAIL jp_pcF got=%h exp=00000200", pcF); end
    total++; if (validD !== 1'b0) begin bad++; $display("FAIL jp_flush got=%b exp=0", validD); end
    step();
    total++; if (instrD !== 32'hFFFF_FDFF) begin bad++; $display("FAIL jp_instr got=%h exp=fffffdff", instrD); end
    total++; if (pcplus4D !== 32'h204) begin bad++; $display("FAIL jp_pcp4 got=%h exp=00000204", pcplus4D); end
  endtask

  task automatic test_wrap();
    reset_dut(0);
    step();
    jumpD = 1'b1; pcjumpD = 32'hFFFF_FFFC;
    step();
    jumpD = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_addr got=%h exp=fffffffc", imem_addr); end
    step();
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wr_next_addr got=%h exp=0", imem_addr); end
    total++; if (pcplus4D !== 32'h0) begin bad++; $display("FAIL wr_pcp4 got=%h exp=0", pcplus4D); end
    total++; if (instrD !== 32'h3) begin bad++; $display("FAIL wr_instr got=%h exp=00000003", instrD); end
  endtask

  task automatic test_reset_mid();
    reset_dut(0);
    repeat (3) step();
    total++; if (validD !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%b exp=1", validD); end
    reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b exp=0", imem_req); end
    total++; if (validD !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", validD); end
    total++; if (pcF !== RST_PC) begin bad++; $display("FAIL rm_pcF got=%h exp=%h", pcF, RST_PC); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rm_addr got=%h exp=0", imem_addr); end
    @(posedge clk);
    #3;
    reset = 1'b0;
    step();
    total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rm_restart_addr got=%h exp=%h", imem_addr, RST_PC); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rm_restart_req got=%b exp=1", imem_req); end
    step();
    total++; if (instrD !== ~RST_PC) begin bad++; $display("FAIL rm_restart_instr got=%h exp=%h", instrD, ~RST_PC); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait3();
    test_stall_hold();
    test_branch_kill();
    test_jump_priority();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
